eu_tx_rd_arb: RTL
=================

EU_TX_RD_ARB -- requirements
Module: eu_tx_rd_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of interconnect requesters sharing one EU tx-buffer read port (range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, width of type_exec_unit_addr.
REQ-003 SHALL have parameter DATA_W, default 32, width of type_exec_unit_data.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, number of failed read attempts before abort (range 2..255; used only under REQ-030).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid_i  input  NUM_REQ  per-requester read request, held until response or withdrawn.
REQ-008 SHALL have port req_addr_i  input  NUM_REQ*ADDR_W  per-requester operand address; slice k belongs to requester k.
REQ-009 SHALL have port resp_valid_o  output  NUM_REQ  one-hot, one-cycle pulse: read completed for requester k.
REQ-010 SHALL have port resp_err_o  output  NUM_REQ  one-hot, one-cycle pulse: read aborted by timeout for requester k.
REQ-011 SHALL have port resp_data_o  output  DATA_W  read data shared by all requesters, valid only with the resp_valid_o pulse.
REQ-012 SHALL have port grant_o  output  NUM_REQ  one-hot current owner, nonzero only in BUSY and DONE.
REQ-013 SHALL have port icon_raddr_o  output  ADDR_W  address to the tx buffer read port.
REQ-014 SHALL have port icon_rvalid_o  output  1  read strobe to the tx buffer.
REQ-015 SHALL have port icon_rdata_i  input  DATA_W  tx buffer read data, same-cycle with icon_rsuccess_i.
REQ-016 SHALL have port icon_rsuccess_i  input  1  tx buffer hit; entry is consumed in the cycle it is high while icon_rvalid_o is high.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-018 IDLE: when any req_valid_i bit is set, SHALL select the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap, latch its index and address, and enter BUSY next cycle; with no request, remain in IDLE.
REQ-019 BUSY: SHALL drive icon_rvalid_o=1 and icon_raddr_o=latched address; later changes on req_addr_i SHALL be ignored.
REQ-020 BUSY with icon_rsuccess_i=1: SHALL register icon_rdata_i and enter DONE.
REQ-021 BUSY with icon_rsuccess_i=0: SHALL retry, remaining in BUSY.
REQ-022 BUSY with the granted req_valid_i bit low: SHALL abort to IDLE with no response pulse and no ptr update; if icon_rsuccess_i is also high that cycle, success SHALL take priority (REQ-020).
REQ-023 DONE: SHALL pulse resp_valid_o[idx] for exactly one cycle with resp_data_o=registered data, set ptr=idx, and return to IDLE.
REQ-024 Latency: request sampled in cycle N, with hit on first attempt, SHALL produce resp_valid_o in cycle N+2; minimum issue interval is 3 cycles.
REQ-025 Outside BUSY, icon_rvalid_o SHALL be 0 and icon_raddr_o SHALL be 0; resp_data_o SHALL be 0 except during DONE.
REQ-026 A requester still asserting req_valid_i in IDLE after its response SHALL be treated as a new request; round-robin then favours other requesters.

Reset
REQ-027 On reset_n low, asynchronously: state=IDLE, ptr=NUM_REQ-1 (requester 0 highest priority), and all outputs 0.
REQ-028 Reset asserted in BUSY or DONE SHALL drop the transaction with no response pulse.
REQ-029 After reset_n rises, the first arbitration SHALL occur on the first rising clock edge.

Configuration
REQ-030 With EU_TX_RD_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL be cleared on BUSY entry and incremented on each failed BUSY cycle. On the TIMEOUT_CYCLES-th consecutive failure, the block SHALL enter DONE, pulse resp_err_o[idx] instead of resp_valid_o, drive resp_data_o=0, and advance ptr.
REQ-031 Without EU_TX_RD_ARB_TIMEOUT_EN: there SHALL be no counter, resp_err_o SHALL be tied to 0, and BUSY SHALL retry indefinitely until success or withdrawal.

Verification
REQ-032 Bench SHALL cover: req_valid_i=0001, addr 0x0012, rsuccess in first BUSY cycle with data 0xDEADBEEF -> resp_valid_o=0001 at N+2, resp_data_o=0xDEADBEEF.
REQ-033 Bench SHALL cover: all four requests held continuously, always hit -> grants 0,1,2,3,0 in order, one response every 3 cycles.
REQ-034 Bench SHALL cover: requester 2 granted, rsuccess low 5 cycles then high -> icon_rvalid_o high 6 cycles, single resp_valid_o=0100.
REQ-035 Bench SHALL cover: requester 1 drops req_valid_i during BUSY -> IDLE next cycle, no pulse, and requester 1 is granted first again if it re-requests with 0 and 1 both requesting.
REQ-036 Bench SHALL cover: macro defined, TIMEOUT_CYCLES=4, never hit -> resp_err_o pulse after 4 BUSY cycles with resp_data_o=0; macro undefined -> BUSY persists for 100 cycles.
REQ-037 Bench SHALL cover: reset_n asserted mid-BUSY -> all outputs 0 immediately; after release, requester 0 wins simultaneous requests 0 and 3.

Source files
------------

// File: rtl/eu_tx_rd_arb.sv
// eu_tx_rd_arb -- round-robin arbiter that lets NUM_REQ interconnect
// requesters share the single read port of the EU tx buffer.
//
// A request is granted in IDLE, the read is retried in BUSY until the tx
// buffer reports a hit (or the owner withdraws), and the result is pulsed
// back to the owner in DONE. All outputs are registered.
//
// Optional feature: define EU_TX_RD_ARB_TIMEOUT_EN to abort a read after
// TIMEOUT_CYCLES consecutive misses and report it on resp_err_o. Without
// the macro resp_err_o is tied low and BUSY retries indefinitely.

module eu_tx_rd_arb #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    output logic [NUM_REQ-1:0]        resp_err_o,
    output logic [DATA_W-1:0]         resp_data_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [ADDR_W-1:0]         icon_raddr_o,
    output logic                      icon_rvalid_o,
    input  logic [DATA_W-1:0]         icon_rdata_i,
    input  logic                      icon_rsuccess_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reject configurations outside the supported range at elaboration.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("eu_tx_rd_arb: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("eu_tx_rd_arb: TIMEOUT_CYCLES must be in 2..255");
    end

    state_t             state_reg;
    logic [IDX_W-1:0]   ptr_reg;     // last served requester
    logic [IDX_W-1:0]   idx_reg;     // current owner

    logic [ADDR_W-1:0]  addr_slice [NUM_REQ];
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [NUM_REQ-1:0] idx_onehot;
    logic               owner_valid;

    // Split the flat address bus into one slice per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_slice
        assign addr_slice[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    end

    // Round-robin pick: first set request bit starting after the last winner.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr_reg) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!sel_found && req_valid_i[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign sel_onehot  = NUM_REQ'(1) << sel_idx;
    assign idx_onehot  = NUM_REQ'(1) << idx_reg;
    assign owner_valid = req_valid_i[idx_reg];

`ifdef EU_TX_RD_ARB_TIMEOUT_EN
    logic [7:0] miss_cnt_reg;
    logic       timeout_hit;

    // The current miss is the TIMEOUT_CYCLES-th when the count already
    // holds TIMEOUT_CYCLES-1 earlier misses.
    assign timeout_hit = (miss_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
`else
    assign resp_err_o = '0;
`endif

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= IDX_W'(NUM_REQ - 1);
            idx_reg       <= '0;
            grant_o       <= '0;
            icon_rvalid_o <= 1'b0;
            icon_raddr_o  <= '0;
            resp_valid_o  <= '0;
            resp_data_o   <= '0;
`ifdef EU_TX_RD_ARB_TIMEOUT_EN
            resp_err_o    <= '0;
            miss_cnt_reg  <= '0;
`endif
        end else begin
            // Response outputs are single-cycle pulses by default.
            resp_valid_o <= '0;
            resp_data_o  <= '0;
`ifdef EU_TX_RD_ARB_TIMEOUT_EN
            resp_err_o   <= '0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (sel_found) begin
                        state_reg     <= ST_BUSY;
                        idx_reg       <= sel_idx;
                        grant_o       <= sel_onehot;
                        icon_rvalid_o <= 1'b1;
                        // Address is captured once; later changes are ignored.
                        icon_raddr_o  <= addr_slice[sel_idx];
`ifdef EU_TX_RD_ARB_TIMEOUT_EN
                        miss_cnt_reg  <= '0;
`endif
                    end
                end

                ST_BUSY: begin
                    if (icon_rsuccess_i) begin
                        // A hit wins even if the owner withdraws this cycle.
                        state_reg     <= ST_DONE;
                        icon_rvalid_o <= 1'b0;
                        icon_raddr_o  <= '0;
                        resp_valid_o  <= idx_onehot;
                        resp_data_o   <= icon_rdata_i;
                    end else if (!owner_valid) begin
                        // Withdrawn: silent abort, fairness pointer untouched.
                        state_reg     <= ST_IDLE;
                        grant_o       <= '0;
                        icon_rvalid_o <= 1'b0;
                        icon_raddr_o  <= '0;
`ifdef EU_TX_RD_ARB_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        state_reg     <= ST_DONE;
                        icon_rvalid_o <= 1'b0;
                        icon_raddr_o  <= '0;
                        resp_err_o    <= idx_onehot;
                    end else begin
                        miss_cnt_reg  <= miss_cnt_reg + 8'd1;
`endif
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    grant_o   <= '0;
                    ptr_reg   <= idx_reg;
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    grant_o       <= '0;
                    icon_rvalid_o <= 1'b0;
                    icon_raddr_o  <= '0;
                end
            endcase
        end
    end

endmodule
